// File: rtl/ps2_cmd_sequencer.sv
// ============================================================================
//  Module   : ps2_cmd_sequencer
//  Purpose  : Issues one host command byte to the PS/2 engine, handles
//             ACK/resend, collects response bytes, forwards idle traffic.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_cmd_sequencer #(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned MAX_RETRIES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_byte,
  input  logic [1:0]  cmd_nresp,
  output logic        cmd_ready,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [23:0] resp_data,
  output logic        tx_we,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_avail,
  input  logic [7:0]  rx_data,
  output logic        rx_pass_valid,
  output logic [7:0]  rx_pass_data
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam logic [20:0] c_timer_load = 21'(TIMEOUT - 1);
  localparam logic [2:0]  c_max_retry  = 3'(MAX_RETRIES);
  localparam logic [7:0]  c_ack        = 8'hFA;
  localparam logic [7:0]  c_resend     = 8'hFE;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cmd_q;
  logic [1:0]  r_nresp_q;
  logic [1:0]  r_resp_left;
  logic [2:0]  r_retry_cnt;
  logic [20:0] r_timer;
  logic [1:0]  r_err_code;
  logic [23:0] r_resp_data;
  logic        r_pass_valid;
  logic [7:0]  r_pass_data;

  logic        w_accept;
  logic        w_tx_we;
  logic        w_timer_load;
  logic        w_resp_load;
  logic        w_resp_shift;
  logic        w_retry_inc;
  logic        w_code_we;
  logic [1:0]  w_code_nxt;
  logic        w_unused;

  assign w_unused = (CLK_FREQ != 0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_tx_we      = 1'b0;
    w_timer_load = 1'b0;
    w_resp_load  = 1'b0;
    w_resp_shift = 1'b0;
    w_retry_inc  = 1'b0;
    w_code_we    = 1'b0;
    w_code_nxt   = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          w_tx_we      = 1'b1;
          w_timer_load = 1'b1;
          w_state_nxt  = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // A byte arriving in the same cycle the timer expires takes priority.
        if (rx_avail) begin
          if (rx_data == c_ack) begin
            if (r_nresp_q == 2'd0) begin
              w_code_we   = 1'b1;
              w_code_nxt  = 2'd0;
              w_state_nxt = S_FINISH;
            end else begin
              w_resp_load  = 1'b1;
              w_timer_load = 1'b1;
              w_state_nxt  = S_WAIT_RESP;
            end
          end else if (rx_data == c_resend) begin
            if (r_retry_cnt < c_max_retry) begin
              w_retry_inc = 1'b1;
              w_state_nxt = S_SEND;
            end else begin
              w_code_we   = 1'b1;
              w_code_nxt  = 2'd2;
              w_state_nxt = S_FINISH;
            end
          end else begin
            w_code_we   = 1'b1;
            w_code_nxt  = 2'd3;
            w_state_nxt = S_FINISH;
          end
        end else if (r_timer == 21'd0) begin
          w_code_we   = 1'b1;
          w_code_nxt  = 2'd1;
          w_state_nxt = S_FINISH;
        end
      end
      S_WAIT_RESP: begin
        if (rx_avail) begin
          w_resp_shift = 1'b1;
          w_timer_load = 1'b1;
          if (r_resp_left == 2'd1) begin
            w_code_we   = 1'b1;
            w_code_nxt  = 2'd0;
            w_state_nxt = S_FINISH;
          end
        end else if (r_timer == 21'd0) begin
          w_code_we   = 1'b1;
          w_code_nxt  = 2'd1;
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cmd_q      <= 8'd0;
      r_nresp_q    <= 2'd0;
      r_resp_left  <= 2'd0;
      r_retry_cnt  <= 3'd0;
      r_timer      <= 21'd0;
      r_err_code   <= 2'd0;
      r_resp_data  <= 24'd0;
      r_pass_valid <= 1'b0;
      r_pass_data  <= 8'd0;
    end else begin
      if (w_accept) begin
        r_cmd_q     <= cmd_byte;
        r_nresp_q   <= cmd_nresp;
        r_retry_cnt <= 3'd0;
        r_err_code  <= 2'd0;
        r_resp_data <= 24'd0;
      end
      if (w_retry_inc) begin
        r_retry_cnt <= r_retry_cnt + 3'd1;
      end
      if (w_timer_load) begin
        r_timer <= c_timer_load;
      end else if (r_timer != 21'd0) begin
        r_timer <= r_timer - 21'd1;
      end
      if (w_resp_load) begin
        r_resp_left <= r_nresp_q;
      end else if (w_resp_shift) begin
        r_resp_left <= r_resp_left - 2'd1;
      end
      if (w_resp_shift) begin
        r_resp_data <= {r_resp_data[15:0], rx_data};
      end
      if (w_code_we) begin
        r_err_code <= w_code_nxt;
      end
      // Only traffic outside a command exchange is forwarded.
      r_pass_valid <= rx_avail && ((r_state == S_IDLE) || (r_state == S_FINISH));
      if (rx_avail && ((r_state == S_IDLE) || (r_state == S_FINISH))) begin
        r_pass_data <= rx_data;
      end
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign done          = (r_state == S_FINISH);
  assign err           = (r_err_code != 2'd0);
  assign err_code      = r_err_code;
  assign resp_data     = r_resp_data;
  assign tx_we         = w_tx_we;
  assign tx_data       = r_cmd_q;
  assign rx_pass_valid = r_pass_valid;
  assign rx_pass_data  = r_pass_data;

endmodule

`default_nettype wire

// File: tb/tb_ps2_cmd_sequencer.sv
// ============================================================================
//  Module   : tb_ps2_cmd_sequencer
//  Purpose  : Table-driven bench with a reactive PS/2 device model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_cmd_sequencer;

  localparam int TIMEOUT     = 150;
  localparam int MAX_RETRIES = 2;
  localparam int BOUND       = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic [1:0]  cmd_nresp;
  logic        cmd_ready;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [23:0] resp_data;
  logic        tx_we;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_avail;
  logic [7:0]  rx_data;
  logic        rx_pass_valid;
  logic [7:0]  rx_pass_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ps2_cmd_sequencer #(
    .CLK_FREQ   (50000000),
    .TIMEOUT    (TIMEOUT),
    .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .sys_clk      (clk),
    .sys_rst      (rst),
    .cmd_valid    (cmd_valid),
    .cmd_byte     (cmd_byte),
    .cmd_nresp    (cmd_nresp),
    .cmd_ready    (cmd_ready),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .resp_data    (resp_data),
    .tx_we        (tx_we),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .rx_avail     (rx_avail),
    .rx_data      (rx_data),
    .rx_pass_valid(rx_pass_valid),
    .rx_pass_data (rx_pass_data)
  );

  // rx holds up to four device bytes, first byte in [31:24].
  typedef struct packed {
    logic [7:0]  cmd;
    logic [1:0]  nresp;
    logic [2:0]  nrx;
    logic [31:0] rx;
    logic [7:0]  delay;
    logic [3:0]  busy;
    logic [1:0]  code;
    logic [23:0] resp;
    logic [2:0]  ntx;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int cd, idx, ntx, npass, first_tx, last_evt, last_fe, done_c, exp_done;
    logic [7:0] b;
    bit got_done;
    cd = -1; idx = 0; ntx = 0; npass = 0; first_tx = -1;
    last_evt = 0; last_fe = -10; done_c = -1; got_done = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_byte = v.cmd; cmd_nresp = v.nresp;
    rx_avail = 1'b0; tx_busy = 1'b0;
    #1 chk($sformatf("v%0d_ready", id), {31'd0, cmd_ready}, 32'd1);
    for (int c = 1; c <= BOUND && !got_done; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      rx_avail  = 1'b0;
      tx_busy   = (c <= int'(v.busy));
      if (cd > 0) cd--;
      if (cd == 0 && idx < int'(v.nrx)) begin
        b = v.rx[31-8*idx -: 8];
        rx_avail = 1'b1; rx_data = b; last_evt = c;
        if (b == 8'hFE) begin
          cd = -1; last_fe = c;
        end else begin
          cd = int'(v.delay);
        end
        idx++;
      end
      #1;
      if (tx_we) begin
        ntx++;
        if (ntx == 1) first_tx = c;
        else chk($sformatf("v%0d_retry_lat", id), c, last_fe + 1);
        chk($sformatf("v%0d_tx_data", id), {24'd0, tx_data}, {24'd0, v.cmd});
        last_evt = c;
        cd = (idx < int'(v.nrx)) ? int'(v.delay) : -1;
      end
      if (rx_pass_valid) npass++;
      if (done) begin
        got_done = 1; done_c = c;
      end
    end
    chk($sformatf("v%0d_done_seen", id), {31'd0, got_done}, 32'd1);
    if (got_done) begin
      exp_done = last_evt + ((v.code == 2'd1) ? TIMEOUT + 1 : 1);
      chk($sformatf("v%0d_done_cycle", id), done_c, exp_done);
      chk($sformatf("v%0d_first_tx", id), first_tx, 1 + int'(v.busy));
      chk($sformatf("v%0d_ntx", id), ntx, int'(v.ntx));
      chk($sformatf("v%0d_err", id), {31'd0, err}, {31'd0, (v.code != 2'd0)});
      chk($sformatf("v%0d_err_code", id), {30'd0, err_code}, {30'd0, v.code});
      chk($sformatf("v%0d_resp", id), {8'd0, resp_data}, {8'd0, v.resp});
      chk($sformatf("v%0d_no_pass", id), npass, 0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_done_1cyc", id), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_idle", id), {31'd0, cmd_ready}, 32'd1);
      chk($sformatf("v%0d_code_held", id), {30'd0, err_code}, {30'd0, v.code});
    end
  endtask

  initial begin
    //           cmd    nr    nrx   rx              dly   busy  code  resp        ntx
    vecs[0] = '{8'hF4, 2'd0, 3'd1, 32'hFA000000, 8'd100, 4'd0, 2'd0, 24'h000000, 3'd1};
    vecs[1] = '{8'hF2, 2'd2, 3'd3, 32'hFAAB8300, 8'd5,   4'd3, 2'd0, 24'h00AB83, 3'd1};
    vecs[2] = '{8'hFF, 2'd0, 3'd3, 32'hFEFEFA00, 8'd4,   4'd0, 2'd0, 24'h000000, 3'd3};
    vecs[3] = '{8'hED, 2'd0, 3'd3, 32'hFEFEFE00, 8'd4,   4'd0, 2'd2, 24'h000000, 3'd3};
    vecs[4] = '{8'hF3, 2'd0, 3'd1, 32'hFC000000, 8'd7,   4'd0, 2'd3, 24'h000000, 3'd1};
    vecs[5] = '{8'hF5, 2'd0, 3'd0, 32'h00000000, 8'd3,   4'd0, 2'd1, 24'h000000, 3'd1};
    vecs[6] = '{8'hE8, 2'd1, 3'd1, 32'hFA000000, 8'd3,   4'd1, 2'd1, 24'h000000, 3'd1};
    vecs[7] = '{8'hF2, 2'd3, 3'd4, 32'hFA112233, 8'd2,   4'd0, 2'd0, 24'h112233, 3'd1};
    vecs[8] = '{8'hE9, 2'd3, 3'd3, 32'hFA010200, 8'd6,   4'd0, 2'd1, 24'h000102, 3'd1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'd0; cmd_nresp = 2'd0;
    tx_busy = 1'b0; rx_avail = 1'b0; rx_data = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready",     {31'd0, cmd_ready},     32'd1);
    chk("rst_done",      {31'd0, done},          32'd0);
    chk("rst_err",       {31'd0, err},           32'd0);
    chk("rst_err_code",  {30'd0, err_code},      32'd0);
    chk("rst_resp",      {8'd0, resp_data},      32'd0);
    chk("rst_tx_we",     {31'd0, tx_we},         32'd0);
    chk("rst_tx_data",   {24'd0, tx_data},       32'd0);
    chk("rst_pass_v",    {31'd0, rx_pass_valid}, 32'd0);
    chk("rst_pass_data", {24'd0, rx_pass_data},  32'd0);

    // Idle passthrough: forwarded one cycle later, single-cycle pulse.
    @(negedge clk);
    rx_avail = 1'b1; rx_data = 8'h1C;
    @(negedge clk);
    rx_avail = 1'b0;
    #1;
    chk("pass_valid", {31'd0, rx_pass_valid}, 32'd1);
    chk("pass_data",  {24'd0, rx_pass_data},  32'h1C);
    @(negedge clk);
    #1;
    chk("pass_pulse", {31'd0, rx_pass_valid}, 32'd0);
    chk("pass_hold",  {24'd0, rx_pass_data},  32'h1C);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Accept and forward in the same IDLE cycle, then reset from WAIT_ACK.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_byte = 8'h55; cmd_nresp = 2'd0;
    rx_avail = 1'b1; rx_data = 8'h3C; tx_busy = 1'b0;
    #1 chk("cc_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; rx_avail = 1'b0;
    #1;
    chk("cc_pass_valid", {31'd0, rx_pass_valid}, 32'd1);
    chk("cc_pass_data",  {24'd0, rx_pass_data},  32'h3C);
    chk("cc_tx_we",      {31'd0, tx_we},         32'd1);
    chk("cc_tx_data",    {24'd0, tx_data},       32'h55);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_wait_ack", {30'd0, 1'b0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_ready",     {31'd0, cmd_ready},     32'd1);
    chk("mrst_done",      {31'd0, done},          32'd0);
    chk("mrst_err_code",  {30'd0, err_code},      32'd0);
    chk("mrst_tx_we",     {31'd0, tx_we},         32'd0);
    chk("mrst_tx_data",   {24'd0, tx_data},       32'd0);
    chk("mrst_pass_v",    {31'd0, rx_pass_valid}, 32'd0);
    chk("mrst_pass_data", {24'd0, rx_pass_data},  32'd0);
    begin
      int ndone;
      ndone = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        #1 if (done) ndone++;
      end
      chk("mrst_no_done", ndone, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_cmd_sequencer.md
# ps2_cmd_sequencer

Host-side command sequencer for the PS/2 port. It accepts one command byte at a time from the CPU-facing Wishbone glue and issues it to the PS/2 transmit/receive engine. It then waits for the device acknowledge (0xFA), re-sends on a resend request (0xFE), and collects up to three response bytes. Bytes that arrive while no command is in flight are forwarded unchanged as a passthrough stream, so keyboard/mouse traffic and command traffic share the one PS/2 engine.

## Interface

Parameters:
- clk_freq, 50000000, system clock frequency in Hz (informational; used to size TIMEOUT).
- TIMEOUT, 1000000, clocks to wait for each expected byte (20 ms at 50 MHz); must be 1..2^21-1.
- MAX_RETRIES, 2, number of re-sends allowed after 0xFE before reporting an error; range 0..7.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  requester offers a command.
- cmd_byte  in  8  command byte to send.
- cmd_nresp  in  2  number of response bytes expected after ACK (0..3).
- cmd_ready  out  1  high only in IDLE; the command is accepted when cmd_valid && cmd_ready.
- done  out  1  one-cycle pulse when a command finishes, whether successful or not.
- err  out  1  result of the last command; 1 = failure. Held until the next accept.
- err_code  out  2  0 = ok, 1 = timeout, 2 = retries exhausted, 3 = unexpected byte. Held until the next accept.
- resp_data  out  24  response bytes; the last-received byte is in [7:0]. Held until the next accept.
- tx_we  out  1  one-cycle write strobe to the PS/2 engine.
- tx_data  out  8  byte for the PS/2 engine; valid while tx_we is high.
- tx_busy  in  1  PS/2 engine transmit in progress.
- rx_avail  in  1  one-cycle pulse: the PS/2 engine received a byte.
- rx_data  in  8  received byte; valid while rx_avail is high.
- rx_pass_valid  out  1  one-cycle pulse forwarding an unsolicited byte.
- rx_pass_data  out  8  forwarded byte; held until the next forward.

## Operation

- Registered state: state (3 bits), cmd_q[7:0], nresp_q[1:0], resp_left[1:0], retry_cnt[2:0], timer[20:0].
- IDLE
  - cmd_ready = 1.
  - On accept: latch cmd_byte into cmd_q and cmd_nresp into nresp_q; clear retry_cnt, err, err_code and resp_data; go to SEND.
- SEND
  - If tx_busy = 1, stay in SEND.
  - Otherwise assert tx_we with tx_data = cmd_q for exactly one cycle, load timer with TIMEOUT-1, and go to WAIT_ACK.
- WAIT_ACK: the timer decrements every cycle. On rx_avail:
  - 0xFA with nresp_q = 0: go to FINISH with err_code 0.
  - 0xFA with nresp_q ≠ 0: set resp_left = nresp_q, reload the timer, go to WAIT_RESP.
  - 0xFE with retry_cnt < MAX_RETRIES: increment retry_cnt, go to SEND.
  - 0xFE with retry_cnt = MAX_RETRIES: go to FINISH with err_code 2.
  - Any other byte: go to FINISH with err_code 3.
  - If the timer is 0 and no rx_avail occurs that cycle: go to FINISH with err_code 1.
- WAIT_RESP
  - On rx_avail: resp_data <= {resp_data[15:0], rx_data}, decrement resp_left, and reload the timer.
  - When resp_left goes from 1 to 0: go to FINISH with err_code 0.
  - If the timer reaches 0 first: go to FINISH with err_code 1; resp_data keeps the partial bytes.
- FINISH
  - done = 1 for one cycle; err = (err_code ≠ 0).
  - Next state is IDLE.
- Passthrough: rx_avail in IDLE or FINISH drives rx_pass_valid = 1 on the next cycle and registers rx_data into rx_pass_data. Bytes received in SEND, WAIT_ACK or WAIT_RESP are consumed and not forwarded.

## Timing

- Reset values:
  - state = IDLE, cmd_ready = 1.
  - done = 0, err = 0, err_code = 0, resp_data = 0.
  - tx_we = 0, tx_data = 0.
  - rx_pass_valid = 0, rx_pass_data = 0.
  - timer = 0, retry_cnt = 0.
- Accept in cycle N: tx_we is high in cycle N+1 if tx_busy was low in N+1. Each cycle tx_busy is high adds one cycle.
- The 0xFE → SEND → tx_we retry path takes 2 cycles.
- A byte on rx_avail is reflected in state and outputs on the following edge. done rises the cycle after the terminating event.
- The timeout fires exactly TIMEOUT cycles after the tx_we cycle, or after the last received byte.
- rx_avail and timer = 0 in the same cycle: the byte is processed and the timeout is ignored.
- cmd_valid and rx_avail in the same IDLE cycle: the command is accepted and the byte is still forwarded.
- cmd_valid held high through FINISH: the next command is accepted in the first IDLE cycle, so there are at least 2 cycles between consecutive tx_we pulses plus the transfer time.
- Reset mid-operation: return to IDLE the next cycle with all outputs at their reset values; no done pulse. An in-flight PS/2 transfer is abandoned by this block; the PS/2 engine resets on the same sys_rst.

## Test plan

- Command 0xF4 with nresp 0; model answers 0xFA 100 cycles after tx_we → one tx_we with tx_data 0xF4; done pulse with err 0, err_code 0.
- Command 0xF2 with nresp 2; model answers 0xFA, 0xAB, 0x83 → resp_data = 0x00AB83, err_code 0; no rx_pass_valid pulses.
- MAX_RETRIES = 2; model answers 0xFE, 0xFE, 0xFA → three tx_we pulses, each carrying the command byte; done with err_code 0.
- Model answers 0xFE three times → three tx_we pulses; done with err 1, err_code 2. A separate run answering 0xFC → err_code 3.
- No answer → done exactly TIMEOUT+1 cycles after tx_we with err_code 1. Repeat with 0xFA then silence, nresp 1 → err_code 1.
- Idle rx_avail 0x1C → rx_pass_valid the next cycle with data 0x1C. Assert sys_rst while in WAIT_ACK → IDLE next cycle, no done, all outputs at reset values.
